// File: rtl/led_pio_sequencer.sv
// LED PIO sequencer: register block, interval-timed pattern engine and the single
// write-port arbiter that sits in front of the LED PIO s1 slave.
module led_pio_sequencer #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        busy
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LEN_W = IDX_W + 1;
  localparam int CNT_W = DIV_W + 1;
  localparam logic [4:0]       DEPTH_L = 5'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic                en_q, en_d;
  logic                os_q, os_d;
  logic                done_q, done_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   dir_q, dir_d;
  logic [DIV_W-1:0]    div_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   pat_q [DEPTH];
  logic                mcs_q, mwn_q;
  logic [DATA_W-1:0]   mwd_q;
  logic                mwr_d;
  logic [DATA_W-1:0]   mdata_d;

  logic wr_s, wr_ctrl_s, wr_div_s, wr_len_s, wr_dir_s, wr_pat_s, pat_hit_s;
  logic last_s, wait_done_s, direct_hold_s, busy_s;
  logic [IDX_W-1:0] pat_rd_idx_s;
  logic [LEN_W-1:0] len_wr_s;

  assign wr_s         = s_chipselect & ~s_write_n;
  assign wr_ctrl_s    = wr_s & (s_address == 4'd0);
  assign wr_div_s     = wr_s & (s_address == 4'd1);
  assign wr_len_s     = wr_s & (s_address == 4'd2);
  assign wr_dir_s     = wr_s & (s_address == 4'd3);
  assign pat_hit_s    = s_address[3] & ({2'b00, s_address[2:0]} < DEPTH_L);
  assign wr_pat_s     = wr_s & pat_hit_s;
  assign pat_rd_idx_s = IDX_W'(s_address[2:0]);
  assign busy_s       = (state_q != IDLE);

  // A shrunk LENGTH or DIVIDER must still terminate the current step, hence >= rather than ==.
  assign last_s        = ({1'b0, idx_q} + LEN_W'(1)) >= len_q;
  assign wait_done_s   = ({1'b0, cnt_q} + CNT_W'(1)) >= {1'b0, div_q};
  assign direct_hold_s = wr_dir_s | pend_q;

  // LENGTH write value clamped into 1..DEPTH
  always_comb begin
    len_wr_s = s_writedata[LEN_W-1:0];
    if (s_writedata == 32'd0) begin
      len_wr_s = LEN_W'(1);
    end else if (s_writedata > 32'(DEPTH)) begin
      len_wr_s = LEN_MAX;
    end else begin
      len_wr_s = s_writedata[LEN_W-1:0];
    end
  end

  // Zero-latency CSR read mux
  always_comb begin
    s_readdata = 32'd0;
    case (s_address)
      4'd0:    s_readdata = {30'd0, os_q, en_q};
      4'd1:    s_readdata = 32'(div_q);
      4'd2:    s_readdata = 32'(len_q);
      4'd3:    s_readdata = 32'(dir_q);
      4'd4:    s_readdata = {20'd0, 4'(idx_q), 6'd0, done_q, busy_s};
      default: begin
        if (pat_hit_s) s_readdata = 32'(pat_q[pat_rd_idx_s]);
        else           s_readdata = 32'd0;
      end
    endcase
  end

  // Next-state logic: direct-write arbitration, CTRL handling and the pattern FSM
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    os_d    = os_q;
    done_d  = done_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    mwr_d   = 1'b0;
    mdata_d = '0;

    // A DIRECT write is issued the cycle after it is latched; a newer write coalesces it.
    if (wr_dir_s) begin
      dir_d  = s_writedata[DATA_W-1:0];
      pend_d = 1'b1;
    end else if (pend_q) begin
      mwr_d   = 1'b1;
      mdata_d = dir_q;
      pend_d  = 1'b0;
    end else begin
      pend_d = 1'b0;
    end

    if (wr_ctrl_s) begin
      en_d   = s_writedata[0];
      os_d   = s_writedata[1];
      done_d = 1'b0;
      if (s_writedata[0]) begin
        state_d = ISSUE;
        idx_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        ISSUE: begin
          if (!direct_hold_s) begin
            mwr_d   = 1'b1;
            mdata_d = pat_q[idx_q];
            if (div_q != '0) begin
              state_d = WAIT;
              cnt_d   = '0;
            end else if (!last_s) begin
              idx_d = idx_q + IDX_W'(1);
            end else if (!os_q) begin
              idx_d = '0;
            end else begin
              state_d = IDLE;
              en_d    = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ISSUE;
          end
        end
        WAIT: begin
          if (!wait_done_s) begin
            cnt_d = cnt_q + DIV_W'(1);
          end else if (!last_s) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ISSUE;
          end else if (!os_q) begin
            idx_d   = '0;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control/status registers, FSM state and registered master port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      os_q    <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      dir_q   <= '0;
      div_q   <= '0;
      len_q   <= LEN_W'(1);
      mcs_q   <= 1'b0;
      mwn_q   <= 1'b1;
      mwd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      os_q    <= os_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      if (wr_div_s) div_q <= s_writedata[DIV_W-1:0];
      if (wr_len_s) len_q <= len_wr_s;
      mcs_q   <= mwr_d;
      mwn_q   <= ~mwr_d;
      mwd_q   <= mdata_d;
    end
  end

  // Pattern table
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_pat_s && ({1'b0, s_address[2:0]} == 4'(i))) pat_q[i] <= s_writedata[DATA_W-1:0];
      end
    end
  end

  assign m_address    = 2'd0;
  assign m_chipselect = mcs_q;
  assign m_write_n    = mwn_q;
  assign m_writedata  = {{(32-DATA_W){1'b0}}, mwd_q};
  assign busy         = busy_s;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Scoreboard bench for led_pio_sequencer: expected PIO writes (value + cycle) are queued
// by the stimulus thread and consumed by an independent master-port monitor.
module tb_led_pio_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  s_address = 4'd0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        busy;

  led_pio_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int t; } exp_t;
  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every PIO write must match the head of the expectation queue
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (m_chipselect || !m_write_n)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got 0x%0h at cycle %0d, expected no write", m_writedata, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", m_writedata, e.data);
        check("wr_cycle", 32'(cyc), 32'(e.t));
        check("wr_strobe", {29'd0, m_address, m_write_n}, 32'd0);
      end
    end
  end

  task automatic push(input logic [31:0] d, input int t);
    exp_t e;
    e.data = d;
    e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    s_chipselect = 1'b1; s_write_n = 1'b0; s_address = a; s_writedata = d;
  endtask

  task automatic cpu_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_chipselect = 1'b0; s_write_n = 1'b1;
    end
  endtask

  // Idle until the next cpu_wr lands in cycle t
  task automatic wait_before(input int t);
    while (cyc < t - 1) cpu_idle(1);
  endtask

  task automatic chk_rd(input string name, input logic [3:0] a, input logic [31:0] req);
    @(posedge clk); #1;
    s_chipselect = 1'b1; s_write_n = 1'b1; s_address = a;
    #1;
    check(name, s_readdata, req);
  endtask

  task automatic chk_idle(input string name);
    check({name, "_master"}, {m_writedata[29:0], m_chipselect, m_write_n}, 32'd1);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  int c;
  logic [31:0] pv [3];

  initial begin
    pv[0] = 32'h001; pv[1] = 32'h002; pv[2] = 32'h004;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst_hold");
    reset_n = 1'b1;
    chk_rd("rst_ctrl", 4'd0, 32'd0);
    chk_rd("rst_div", 4'd1, 32'd0);
    chk_rd("rst_len", 4'd2, 32'd1);
    chk_rd("rst_direct", 4'd3, 32'd0);
    chk_rd("rst_status", 4'd4, 32'd0);
    chk_rd("rst_pat0", 4'd8, 32'd0);
    chk_rd("rst_pat7", 4'd15, 32'd0);
    chk_idle("rst");

    // LENGTH clamping and unmapped address
    cpu_wr(4'd2, 32'd0);
    chk_rd("len_zero", 4'd2, 32'd1);
    cpu_wr(4'd2, 32'd20);
    chk_rd("len_over", 4'd2, 32'd8);
    cpu_wr(4'd6, 32'hFFFF_FFFF);
    chk_rd("unmapped", 4'd6, 32'd0);

    // Direct write with engine idle
    cpu_wr(4'd3, 32'h155);
    c = cyc;
    push(32'h155, c + 2);
    cpu_idle(3);
    chk_rd("direct_rb", 4'd3, 32'h155);

    // One-shot sequence, DIVIDER=3 -> period 4
    cpu_wr(4'd8, 32'h001);
    cpu_wr(4'd9, 32'h002);
    cpu_wr(4'd10, 32'h004);
    cpu_wr(4'd2, 32'd3);
    cpu_wr(4'd1, 32'd3);
    cpu_wr(4'd0, 32'h3);
    c = cyc;
    push(32'h001, c + 2); push(32'h002, c + 6); push(32'h004, c + 10);
    wait_before(c + 16);
    chk_rd("oneshot_status", 4'd4, 32'h202);
    chk_rd("oneshot_ctrl", 4'd0, 32'h2);
    check("oneshot_busy", {31'd0, busy}, 32'd0);

    // Looping, DIVIDER=0 -> one write per cycle, then disable
    cpu_wr(4'd1, 32'd0);
    cpu_wr(4'd0, 32'h1);
    c = cyc;
    for (int i = 0; i < 7; i++) push(pv[i % 3], c + 2 + i);
    wait_before(c + 8);
    cpu_wr(4'd0, 32'h0);
    cpu_idle(6);
    chk_idle("loop_stop");

    // Looping with DIRECT pre-emption and coalesced back-to-back DIRECT writes
    cpu_wr(4'd1, 32'd3);
    cpu_wr(4'd0, 32'h1);
    c = cyc;
    push(32'h001, c + 2);  push(32'h3FF, c + 7);  push(32'h002, c + 8);
    push(32'h004, c + 12); push(32'h001, c + 16); push(32'h055, c + 19);
    push(32'h002, c + 20);
    wait_before(c + 5);
    cpu_wr(4'd3, 32'h3FF);
    wait_before(c + 16);
    cpu_wr(4'd3, 32'h0AA);
    cpu_wr(4'd3, 32'h055);
    wait_before(c + 21);
    cpu_wr(4'd0, 32'h0);
    cpu_idle(6);
    chk_rd("direct_rb2", 4'd3, 32'h055);
    chk_idle("preempt_stop");

    // Asynchronous reset mid-sequence drops the in-flight write
    cpu_wr(4'd1, 32'd0);
    cpu_wr(4'd0, 32'h1);
    c = cyc;
    push(32'h001, c + 2); push(32'h002, c + 3);
    wait_before(c + 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("midrst");
    chk_rd("midrst_status", 4'd4, 32'd0);
    chk_rd("midrst_ctrl", 4'd0, 32'd0);
    chk_rd("midrst_len", 4'd2, 32'd1);
    chk_rd("midrst_pat0", 4'd8, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cpu_idle(8);
    chk_idle("post_rst");

    // Re-enable after reset: LENGTH=1, DIVIDER=0, one-shot -> single write
    cpu_wr(4'd8, 32'h2AA);
    cpu_wr(4'd0, 32'h3);
    c = cyc;
    push(32'h2AA, c + 2);
    cpu_idle(5);
    chk_rd("reenable_status", 4'd4, 32'h002);

    cpu_idle(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
